// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical-memory line port between the icache and dcache.
// A granted request is latched and replayed downstream until pmem_resp completes it.
module cache_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LINE_W  = 256,
  parameter bit          D_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic              i_pmem_resp,
  output logic [LINE_W-1:0] i_pmem_rdata,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic              d_pmem_resp,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_d_q, last_d_d;   // 1: dcache was granted most recently
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              i_pend_c, d_pend_c, grant_d_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_d_q <= ~D_FIRST;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
    end
  end

  // Latched registers are cleared on completion so downstream outputs read 0 in IDLE.
  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    i_pend_c  = i_pmem_read;
    d_pend_c  = d_pmem_read | d_pmem_write;
    grant_d_c = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d_c = d_pend_c & (~i_pend_c | ~last_d_q);
        if (grant_d_c) begin
          state_d  = SERVE_D;
          last_d_d = 1'b1;
          addr_d   = d_pmem_address;
          wdata_d  = d_pmem_wdata;
          wr_d     = d_pmem_write;
          rd_d     = d_pmem_read & ~d_pmem_write;
        end else if (i_pend_c) begin
          state_d  = SERVE_I;
          last_d_d = 1'b0;
          addr_d   = i_pmem_address;
          wdata_d  = '0;
          wr_d     = 1'b0;
          rd_d     = 1'b1;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_d = IDLE;
          addr_d  = '0;
          wdata_d = '0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pmem_read    = rd_q;
  assign pmem_write   = wr_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  // Completion and fill data are forwarded straight through to the current owner only.
  assign i_pmem_resp  = (state_q == SERVE_I) & pmem_resp;
  assign d_pmem_resp  = (state_q == SERVE_D) & pmem_resp;
  assign i_pmem_rdata = (state_q == SERVE_I) ? pmem_rdata : '0;
  assign d_pmem_rdata = (state_q == SERVE_D) ? pmem_rdata : '0;

  rw_exclusive_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(d_pmem_read && d_pmem_write));

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed test-plan steps followed by randomized
// traffic, all compared every cycle against a transaction-level reference model.
module tb_cache_arbiter;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned LINE_W  = 256;
  localparam bit          D_FIRST = 1'b1;

  logic              clk;
  logic              rst_n = 1'b0;
  logic              i_pmem_read = 1'b0;
  logic [ADDR_W-1:0] i_pmem_address = '0;
  logic              i_pmem_resp;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              d_pmem_read = 1'b0;
  logic              d_pmem_write = 1'b0;
  logic [ADDR_W-1:0] d_pmem_address = '0;
  logic [LINE_W-1:0] d_pmem_wdata = '0;
  logic              d_pmem_resp;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic              pmem_resp = 1'b0;
  logic [LINE_W-1:0] pmem_rdata = '0;

  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .D_FIRST(D_FIRST)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_resp(i_pmem_resp), .i_pmem_rdata(i_pmem_rdata),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_resp(d_pmem_resp), .d_pmem_rdata(d_pmem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: who holds the port (0 none, 1 icache, 2 dcache) and the replayed transaction.
  int                m_owner = 0;
  bit                m_last_d = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [LINE_W-1:0] m_wdata = '0;
  bit                m_rd = 1'b0, m_wr = 1'b0;

  int                mem_lat = 0;
  bit                mem_pat_en = 1'b0;
  logic [LINE_W-1:0] mem_pat = '0;
  bit                noise_en = 1'b0;
  bit                saw_i_resp = 1'b0, saw_d_resp = 1'b0;
  int                n_strobe = 0;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  // One rising edge seen at transaction level: reset, completion, or a round-robin grant.
  task automatic model_edge();
    bit ip, dp, take_d;
    if (!rst_n) begin
      m_owner = 0; m_last_d = !D_FIRST; m_addr = '0; m_wdata = '0; m_rd = 0; m_wr = 0;
    end else if (m_owner != 0) begin
      if (pmem_resp) begin
        m_owner = 0; m_addr = '0; m_wdata = '0; m_rd = 0; m_wr = 0;
      end
    end else begin
      ip = i_pmem_read;
      dp = d_pmem_read || d_pmem_write;
      take_d = (ip && dp) ? !m_last_d : dp;
      if (take_d) begin
        m_owner = 2; m_last_d = 1; m_addr = d_pmem_address; m_wdata = d_pmem_wdata;
        m_wr = d_pmem_write; m_rd = !d_pmem_write;
      end else if (ip) begin
        m_owner = 1; m_last_d = 0; m_addr = i_pmem_address; m_wdata = '0; m_rd = 1; m_wr = 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    if (pmem_read || pmem_write) begin
      if (mem_lat == 0) begin
        pmem_resp  = 1'b1;
        pmem_rdata = mem_pat_en ? mem_pat : rand_line();
        mem_lat    = $urandom_range(0, 3);
      end else begin
        pmem_resp  = 1'b0;
        pmem_rdata = rand_line();
        mem_lat--;
      end
    end else begin
      pmem_resp  = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      pmem_rdata = rand_line();
    end
    #1;
    chk("pmem_read",    LINE_W'(pmem_read),    LINE_W'(m_rd));
    chk("pmem_write",   LINE_W'(pmem_write),   LINE_W'(m_wr));
    chk("pmem_address", LINE_W'(pmem_address), LINE_W'(m_addr));
    chk("pmem_wdata",   pmem_wdata,            m_wdata);
    chk("i_pmem_resp",  LINE_W'(i_pmem_resp),  LINE_W'((m_owner == 1) && pmem_resp));
    chk("d_pmem_resp",  LINE_W'(d_pmem_resp),  LINE_W'((m_owner == 2) && pmem_resp));
    chk("i_pmem_rdata", i_pmem_rdata,          (m_owner == 1) ? pmem_rdata : '0);
    chk("d_pmem_rdata", d_pmem_rdata,          (m_owner == 2) ? pmem_rdata : '0);
    saw_i_resp = i_pmem_resp;
    saw_d_resp = d_pmem_resp;
    if (pmem_read || pmem_write) n_strobe++;
  endtask

  task automatic clear_reqs();
    i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0;
  endtask

  task automatic do_reset(input int n);
    clear_reqs();
    rst_n = 1'b0;
    repeat (n) cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    bit                done;
    int                d_resp_cyc, i_first, start, nresp;
    int                order[$];
    logic [LINE_W-1:0] wd;

    // Reset, then idle
    do_reset(3);
    repeat (5) cycle();
    chk("idle_strobes", LINE_W'({pmem_read, pmem_write}), '0);
    chk("idle_address", LINE_W'(pmem_address), '0);

    // Single icache miss with a 4-cycle memory
    mem_lat = 3; mem_pat_en = 1; mem_pat = {8{32'hDEADBEEF}};
    i_pmem_read = 1; i_pmem_address = 32'h0000_1040;
    n_strobe = 0; done = 0; start = cyc; i_first = -1;
    for (int k = 0; k < 30 && !done; k++) begin
      cycle();
      if (pmem_read && i_first < 0) i_first = cyc;
      if (pmem_read) chk("imiss_addr", LINE_W'(pmem_address), LINE_W'(32'h1040));
      if (saw_i_resp) begin
        chk("imiss_rdata", i_pmem_rdata, {8{32'hDEADBEEF}});
        i_pmem_read = 0; done = 1;
      end
    end
    chk("imiss_done", LINE_W'(done), LINE_W'(1));
    chk("imiss_strobe_cycles", LINE_W'(n_strobe), LINE_W'(4));
    chk("imiss_latency", LINE_W'(i_first - start), LINE_W'(1));
    mem_pat_en = 0;
    cycle();

    // First conflict after reset: dcache write-back wins, icache follows 2 cycles after its resp
    do_reset(2);
    wd = rand_line();
    mem_lat = 1;
    d_pmem_write = 1; d_pmem_address = 32'h0000_2000; d_pmem_wdata = wd;
    i_pmem_read = 1;  i_pmem_address = 32'h0000_5000;
    done = 0; d_resp_cyc = -100; i_first = -1;
    for (int k = 0; k < 40 && !done; k++) begin
      cycle();
      if (pmem_write) begin
        chk("conflict_d_addr", LINE_W'(pmem_address), LINE_W'(32'h2000));
        chk("conflict_wdata", pmem_wdata, wd);
      end
      if (saw_d_resp) begin d_resp_cyc = cyc; d_pmem_write = 0; end
      if (pmem_read && i_first < 0) begin
        i_first = cyc;
        chk("conflict_d_before_i", LINE_W'(d_resp_cyc > 0), LINE_W'(1));
      end
      if (saw_i_resp) begin i_pmem_read = 0; done = 1; end
    end
    chk("conflict_done", LINE_W'(done), LINE_W'(1));
    chk("conflict_gap", LINE_W'(i_first - d_resp_cyc), LINE_W'(2));

    // Sustained contention: grants must alternate D,I,D,I,D,I
    d_pmem_read = 1; d_pmem_address = 32'h0000_6000;
    i_pmem_read = 1; i_pmem_address = 32'h0000_7000;
    nresp = 0;
    for (int k = 0; k < 200 && nresp < 6; k++) begin
      cycle();
      if (saw_d_resp) begin order.push_back(2); nresp++; end
      if (saw_i_resp) begin order.push_back(1); nresp++; end
    end
    clear_reqs();
    chk("sustain_count", LINE_W'(order.size()), LINE_W'(6));
    foreach (order[k]) chk($sformatf("sustain_grant%0d", k), LINE_W'(order[k]), LINE_W'((k % 2 == 0) ? 2 : 1));
    cycle();

    // Address change after grant is ignored
    mem_lat = 4;
    d_pmem_read = 1; d_pmem_address = 32'h0000_3000;
    done = 0;
    for (int k = 0; k < 30 && !done; k++) begin
      cycle();
      if (pmem_read) chk("hold_addr", LINE_W'(pmem_address), LINE_W'(32'h3000));
      if (k == 1) d_pmem_address = 32'h0000_3FE0;
      if (saw_d_resp) begin d_pmem_read = 0; done = 1; end
    end
    chk("hold_done", LINE_W'(done), LINE_W'(1));
    cycle();

    // Reset during an active write-back, then a normal icache fill
    mem_lat = 10;
    d_pmem_write = 1; d_pmem_address = 32'h0000_4000; d_pmem_wdata = rand_line();
    repeat (3) cycle();
    chk("abort_pre_write", LINE_W'(pmem_write), LINE_W'(1));
    rst_n = 1'b0;
    cycle();
    chk("abort_strobes", LINE_W'({pmem_read, pmem_write}), '0);
    rst_n = 1'b1; d_pmem_write = 0;
    cycle();
    mem_lat = 2;
    i_pmem_read = 1; i_pmem_address = 32'h0000_8040;
    done = 0;
    for (int k = 0; k < 30 && !done; k++) begin
      cycle();
      if (pmem_read) chk("post_abort_addr", LINE_W'(pmem_address), LINE_W'(32'h8040));
      if (saw_i_resp) begin i_pmem_read = 0; done = 1; end
    end
    chk("post_abort_done", LINE_W'(done), LINE_W'(1));

    // Randomized traffic with resp noise while idle
    noise_en = 1;
    for (int k = 0; k < 3000; k++) begin
      if (saw_i_resp) i_pmem_read = 0;
      else if (!i_pmem_read && $urandom_range(0, 2) == 0) begin
        i_pmem_read = 1; i_pmem_address = ADDR_W'($urandom) & ~ADDR_W'(31);
      end
      if (saw_d_resp) begin d_pmem_read = 0; d_pmem_write = 0; end
      else if (!(d_pmem_read || d_pmem_write) && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 1) d_pmem_write = 1; else d_pmem_read = 1;
        d_pmem_address = ADDR_W'($urandom) & ~ADDR_W'(31);
        d_pmem_wdata = rand_line();
      end else if ((d_pmem_read || d_pmem_write) && $urandom_range(0, 7) == 0)
        d_pmem_address = ADDR_W'($urandom) & ~ADDR_W'(31);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single physical-memory port between the instruction cache and the data cache; both caches present the standard cache-to-pmem line interface.
- Each granted transaction is latched and replayed to the downstream memory, with ownership held until `pmem_resp`.
- Sits between the two cache instances and physical memory (or the L2) in the pipelined processor top.
- Arbitration is round-robin, so neither cache starves under sustained misses.

Parameters:
- ADDR_W, 32, byte-address width of all address ports
- LINE_W, 256, cache-line width of all data ports
- D_FIRST, 1, owner preferred on the first conflict after reset (1 = dcache, 0 = icache)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- i_pmem_read  in  1  icache line-fill request
- i_pmem_address  in  ADDR_W  icache line address
- i_pmem_resp  out  1  icache completion pulse
- i_pmem_rdata  out  LINE_W  icache fill data
- d_pmem_read  in  1  dcache line-fill request
- d_pmem_write  in  1  dcache write-back request
- d_pmem_address  in  ADDR_W  dcache line address
- d_pmem_wdata  in  LINE_W  dcache write-back data
- d_pmem_resp  out  1  dcache completion pulse
- d_pmem_rdata  out  LINE_W  dcache fill data
- pmem_read  out  1  downstream read strobe
- pmem_write  out  1  downstream write strobe
- pmem_address  out  ADDR_W  downstream address
- pmem_wdata  out  LINE_W  downstream write data
- pmem_resp  in  1  downstream completion
- pmem_rdata  in  LINE_W  downstream read data

Behaviour:
- Reset: `rst_n=0` at a rising edge forces the following:
  - state = IDLE
  - `last_grant` = icache if `D_FIRST=1`, otherwise dcache
  - all latched address/data/op registers = 0
- Outputs while in reset and in IDLE:
  - `pmem_read`, `pmem_write`, `i_pmem_resp`, `d_pmem_resp` = 0
  - `pmem_address`, `pmem_wdata` = 0
- States:
  - IDLE: no owner.
  - SERVE_I: icache owns the port.
  - SERVE_D: dcache owns the port.
- A requester is pending when:
  - icache: `i_pmem_read`
  - dcache: `d_pmem_read | d_pmem_write`
- IDLE transitions:
  - Only one requester pending: grant it at the next edge.
  - Both pending: grant the one that is not `last_grant`.
  - On grant: latch address, op and wdata (dcache), and update `last_grant`.
  - No requester pending: stay in IDLE.
- Simultaneous `d_pmem_read` and `d_pmem_write` is illegal. The latched op is write and the read is ignored; an assertion flags it in simulation.
- SERVE_x outputs:
  - `pmem_read` / `pmem_write` driven from the latched op.
  - `pmem_address` / `pmem_wdata` driven from the latched registers, held stable for the whole transaction.
  - Changes on requester inputs after grant are ignored.
- Response:
  - `x_pmem_resp = pmem_resp` combinationally while in SERVE_x; the other requester's resp stays 0.
  - `x_pmem_rdata = pmem_rdata` combinationally for the owner; the non-owner's rdata is 0.
  - At the edge where `pmem_resp=1`, return to IDLE. Downstream strobes drop the following cycle.
- Latency:
  - Request in IDLE at cycle N gives the downstream strobe at cycle N+1.
  - Resp at cycle M gives IDLE at M+1.
  - The earliest next grant is at the M+1 edge, so the next strobe is at M+2.
- A requester that raises a request during another's service waits; its request must stay asserted, and the arbiter never drops a pending request.
- `pmem_resp` while in IDLE is ignored (no resp forwarded, no state change).
- Reset mid-transaction aborts immediately; the downstream memory tolerates strobe removal.
- No combinational path from requester inputs to downstream outputs; all downstream outputs are registered.

Test Plan:
- Reset then idle: hold `rst_n=0` 3 cycles, release, no requests for 5 cycles → all outputs 0, state IDLE.
- Single icache miss: `i_pmem_read=1`, addr 0x0000_1040, memory resp after 4 cycles with rdata = {8{32'hDEADBEEF}} → `pmem_read` high cycles N+1..N+4, `pmem_address`=0x1040, one-cycle `i_pmem_resp` with that data, `d_pmem_resp` stays 0.
- Simultaneous first conflict, `D_FIRST=1`: both requests at cycle N → dcache served first (write-back of 0x2000, `pmem_wdata` matching), then icache granted, with the icache strobe appearing 2 cycles after the dcache resp.
- Sustained contention: both requesters continuously pending for 6 transactions → grants alternate D,I,D,I,D,I; no requester waits more than one transaction.
- Input change after grant: dcache changes addr 0x3000→0x3FE0 mid-transaction → `pmem_address` stays 0x3000 until resp.
- Reset mid-transaction: `rst_n=0` while `pmem_write` is active → next cycle all strobes 0 and state IDLE; a following icache request is served normally.
